temporizador_multicanal: RTL

//  Parametrised sequential motor timer: on enter, runs N channels in order 0..N-1.

---
 rtl/temporizador_multicanal_pkg.sv | 19 +
 rtl/temporizador_multicanal_if.sv | 49 ++++
 rtl/temporizador_multicanal_selector_siguiente_canal.sv | 25 ++
 rtl/temporizador_multicanal.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/temporizador_multicanal_pkg.sv
// Shared types and constants for the multichannel motor timer.
package temporizador_multicanal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } estado_t;

  localparam int unsigned N_CANALES_DEF = 3;
  localparam int unsigned CNT_W_DEF     = 5;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/temporizador_multicanal_if.sv
// Recipe-loader / motor-driver bus of the multichannel timer.
// Optional pause input present when TEMPO_PAUSE_EN is defined.
interface temporizador_multicanal_if #(
  parameter int unsigned N_CANALES = temporizador_multicanal_pkg::N_CANALES_DEF,
  parameter int unsigned CNT_W     = temporizador_multicanal_pkg::CNT_W_DEF
);
  localparam int unsigned IDX_W = temporizador_multicanal_pkg::idx_w(N_CANALES);

  logic                         enter;
  logic                         abort;
`ifdef TEMPO_PAUSE_EN
  logic                         pausa;
`endif
  logic [N_CANALES*CNT_W-1:0]   ciclos;
  logic [N_CANALES-1:0]         motor_on;
  logic [N_CANALES-1:0]         flags;
  logic [IDX_W-1:0]             canal;
  logic                         busy;
  logic                         done;

  modport master (
    output enter,
    output abort,
`ifdef TEMPO_PAUSE_EN
    output pausa,
`endif
    output ciclos,
    input  motor_on,
    input  flags,
    input  canal,
    input  busy,
    input  done
  );

  modport slave (
    input  enter,
    input  abort,
`ifdef TEMPO_PAUSE_EN
    input  pausa,
`endif
    input  ciclos,
    output motor_on,
    output flags,
    output canal,
    output busy,
    output done
  );

endinterface

// File: rtl/temporizador_multicanal_selector_siguiente_canal.sv
// Priority search for the next channel with a non-zero on-time.
module selector_siguiente_canal #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] actual,
  input  logic             desde_inicio,
  output logic [IDX_W-1:0] siguiente,
  output logic             encontrado
);

  // Lowest qualifying index: any from the start, otherwise strictly above actual.
  always_comb begin
    siguiente  = '0;
    encontrado = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!encontrado && mask[i] && (desde_inicio || (IDX_W'(i) > actual))) begin
        siguiente  = IDX_W'(i);
        encontrado = 1'b1;
      end
    end
  end

endmodule

// File: rtl/temporizador_multicanal.sv
// Sequential multichannel motor timer: runs each channel for its latched
// on-time in order, skipping zero-length channels, then pulses done.
// Optional feature macro: TEMPO_PAUSE_EN (adds pausa input on the bus).
module temporizador_multicanal
  import temporizador_multicanal_pkg::*;
#(
  parameter int unsigned N_CANALES = N_CANALES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  temporizador_multicanal_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(N_CANALES);

  typedef logic [N_CANALES-1:0][CNT_W-1:0] ciclos_t;

  estado_t              estado_q, estado_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     canal_q, canal_d;
  ciclos_t              lat_q, lat_d;

  ciclos_t              ciclos_in;
  logic [N_CANALES-1:0] nz_in, nz_lat, sel_mask;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 en_idle_c;
  logic [CNT_W-1:0]     len_act_c;
  logic                 ultimo_c;
  logic                 pausa_c;

  assign ciclos_in = bus.ciclos;
  assign en_idle_c = (estado_q == ST_IDLE);
  assign len_act_c = lat_q[canal_q];
  assign ultimo_c  = (cnt_q == (len_act_c - CNT_W'(1)));

`ifdef TEMPO_PAUSE_EN
  assign pausa_c = bus.pausa;
`else
  assign pausa_c = 1'b0;
`endif

  // Non-zero masks: live inputs for the first pick, snapshot while running.
  always_comb begin
    nz_in  = '0;
    nz_lat = '0;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      nz_in[i]  = |ciclos_in[i];
      nz_lat[i] = |lat_q[i];
    end
  end

  assign sel_mask = en_idle_c ? nz_in : nz_lat;

  selector_siguiente_canal #(
    .N     (N_CANALES),
    .IDX_W (IDX_W)
  ) u_selector (
    .mask         (sel_mask),
    .actual       (canal_q),
    .desde_inicio (en_idle_c),
    .siguiente    (sel_idx),
    .encontrado   (sel_found)
  );

  // State, counter, channel and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ST_IDLE;
      cnt_q    <= '0;
      canal_q  <= '0;
      lat_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      canal_q  <= canal_d;
      lat_q    <= lat_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    canal_d  = canal_q;
    lat_d    = lat_q;
    unique case (estado_q)
      ST_IDLE: begin
        if (bus.enter && !bus.abort) begin
          lat_d   = ciclos_in;
          cnt_d   = '0;
          canal_d = sel_idx;
          estado_d = sel_found ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          estado_d = ST_IDLE;
          cnt_d    = '0;
          canal_d  = '0;
        end else if (pausa_c) begin
          cnt_d = cnt_q;
        end else if (ultimo_c) begin
          cnt_d = '0;
          if (sel_found) begin
            canal_d = sel_idx;
          end else begin
            estado_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        estado_d = ST_IDLE;
        cnt_d    = '0;
        canal_d  = '0;
      end
      default: begin
        estado_d = ST_IDLE;
        cnt_d    = '0;
        canal_d  = '0;
      end
    endcase
  end

  // Output decode from registered state; abort masks flags/done, pause masks motors.
  always_comb begin
    bus.motor_on = '0;
    bus.flags    = '0;
    bus.busy     = (estado_q == ST_RUN);
    bus.done     = (estado_q == ST_DONE) && !bus.abort;
    bus.canal    = canal_q;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      if ((estado_q == ST_RUN) && !pausa_c && (canal_q == IDX_W'(i))) begin
        bus.motor_on[i] = 1'b1;
        bus.flags[i]    = ultimo_c && !bus.abort;
      end
    end
  end

endmodule
